// File: rtl/fp_op_sequencer_if.sv
// Command / response / FP-unit bundle for the half-precision op sequencer.
// master = issuing side plus the FP unit model, slave = sequencer.
interface fp_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [1:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        busy;
  logic [15:0] fp_a;
  logic [15:0] fp_b;
  logic [1:0]  fp_sel;
  logic [15:0] fp_result;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, fp_result,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op, busy, fp_a, fp_b, fp_sel
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, fp_result,
    output cmd_ready, rsp_valid, rsp_data, rsp_op, busy, fp_a, fp_b, fp_sel
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// Issues one FP op at a time: holds operands on the FP unit, waits the
// op-specific pipeline latency, captures fpResult and returns it on a
// valid/ready response channel.
module fp_op_sequencer #(
  parameter int ADDSUB_LAT = 3,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 6,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              areset,
  fp_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   lat_d;
  logic [15:0]        fp_a_q, fp_b_q, rsp_data_q;
  logic [1:0]         fp_sel_q, rsp_op_q;
  logic               rsp_valid_q, busy_q, rdy_q;

  // Latency of the op being offered on the command channel.
  always_comb begin
    lat_d = CNT_W'(ADDSUB_LAT);
    case (bus.cmd_op)
      2'b10:   lat_d = CNT_W'(MUL_LAT);
      2'b11:   lat_d = CNT_W'(DIV_LAT);
      default: lat_d = CNT_W'(ADDSUB_LAT);
    endcase
  end

  // Sequencer FSM; all outputs registered. Operands only move on accept so
  // the FP pipeline sees them stable for the whole wait.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fp_a_q      <= '0;
      fp_b_q      <= '0;
      fp_sel_q    <= '0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && rdy_q) begin
            fp_a_q   <= bus.cmd_a;
            fp_b_q   <= bus.cmd_b;
            fp_sel_q <= bus.cmd_op;
            rsp_op_q <= bus.cmd_op;
            cnt_q    <= lat_d;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          // Count of 1 means this edge is exactly LAT edges after accept.
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q  <= bus.fp_result;
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // Ready rises only after the handshake, so no same-cycle accept.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.busy      = busy_q;
  assign bus.fp_a      = fp_a_q;
  assign bus.fp_b      = fp_b_q;
  assign bus.fp_sel    = fp_sel_q;

endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
Initiator-side front end for the 16-bit half-precision floatingPoint unit. It accepts one operation at a time from a command valid/ready interface, drives the FP unit's a/b/selectFPOperation inputs and holds them stable. It waits the op-specific pipeline latency, captures fpResult and returns it on a response valid/ready interface. It replaces hand-timed bench stimulus and is the block the manipulator control datapath uses to issue FP work.

Parameters:
ADDSUB_LAT, 3, cycles from FP input change to valid fpResult for add/sub (must be >=1)
MUL_LAT, 3, same for multiply (>=1)
DIV_LAT, 6, same for divide (>=1)
CNT_W, 4, latency counter width; must hold max(ADDSUB_LAT, MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, all logic on rising edge
areset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_a  in  16  operand a, IEEE half
cmd_b  in  16  operand b, IEEE half
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  16  captured fpResult
rsp_op  out  2  op code that produced rsp_data
busy  out  1  high in WAIT or RESP
fp_a  out  16  to FP unit a
fp_b  out  16  to FP unit b
fp_sel  out  2  to FP unit selectFPOperation
fp_result  in  16  from FP unit fpResult

Behaviour:
- Reset (areset==0 at a clk edge): state IDLE, counter 0. fp_a, fp_b, fp_sel, rsp_data and rsp_op are 0. rsp_valid and busy are 0; cmd_ready is 1 after the reset edge. Reset overrides all other events and aborts any in-flight op with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE: cmd_ready=1, busy=0. On the edge where cmd_valid&&cmd_ready (edge k):
  - register fp_a<=cmd_a, fp_b<=cmd_b, fp_sel<=cmd_op, rsp_op<=cmd_op;
  - load the counter with LAT(cmd_op): ADDSUB_LAT for 00/01, MUL_LAT for 10, DIV_LAT for 11;
  - go to WAIT.
- WAIT: cmd_ready=0, busy=1, counter decrements each edge. On the edge where the counter is 1 (edge k+LAT), rsp_data<=fp_result, rsp_valid<=1, go to RESP. The captured value is fp_result sampled exactly LAT cycles after fp_a/fp_b/fp_sel changed.
- RESP: rsp_valid=1, busy=1, cmd_ready=0. rsp_data and rsp_op are held stable until the handshake. On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE. cmd_ready rises the cycle after; no accept in the same cycle as the response handshake.
- fp_a, fp_b and fp_sel change only on command accept and keep their last values in all other states, so the FP pipeline sees stable operands.
- rsp_ready held high in RESP gives a minimum of LAT+2 cycles per op. rsp_ready stalled indefinitely: the block stays in RESP and holds its outputs.
- cmd_valid while not ready: ignored. No buffering and no requirement on the source to hold it, but the standard valid/ready rule applies.
- cmd_valid or rsp_ready asserted in the reset cycle: ignored.
- rsp_data is a passthrough of FP unit bits; no NaN or exception interpretation.

Test Plan:
- Reset: areset=0 for 2 cycles with cmd_valid=1 -> all outputs 0, then cmd_ready=1 and no accept during reset.
- Add: cmd_a=cmd_b=16'h4100, op 00, FP model latency 3, rsp_ready=1 -> fp_a=16'h4100 one edge after accept; rsp_valid 3 edges after accept with rsp_data=16'h4500, rsp_op=00; cmd_ready returns 1 cycle after the handshake.
- Sub then Mul back-to-back (cmd_valid held): same operands -> first response 16'h0000 (op 01), second 16'h4640 (op 10). Second accept no earlier than the cycle after the first handshake. fp_a/fp_b stable across WAIT.
- Div with DIV_LAT=6: 16'h4100/16'h4100 -> rsp_data=16'h3C00 exactly 6 edges after accept. A model that changes fp_result at edge 5 must not be captured.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_op constant, cmd_ready=0, new cmd_valid ignored; rsp_ready=1 completes the transfer once.
- Reset mid-op: areset=0 during WAIT of a divide -> next cycle IDLE, rsp_valid never asserts for that op, fp_* outputs 0.
